// File: rtl/wave_osc_if.sv
// ---------------------------------------------------------------------------
// wave_osc_if -- control and sample bus of the tone oscillator.
//
// Signals:
//   divider     [17:0] clk cycles per phase step, 0 halts the oscillator
//   mode        [1:0]  waveform: 0 square, 1 saw, 2 triangle, 3 sine
//   strobe             level, high while a note key is held
//   sample      [7:0]  registered unsigned audio sample, midscale 128
//   sample_tick        one-cycle pulse on every phase advance
//   active             high while the gate state machine is not IDLE
//   dbg_state   [1:0]  current gate state (observability only)
//
// Handshake: there is no valid/ready pair on this bus. divider, mode and
// strobe are plain levels sampled on every rising clk edge; the oscillator
// never back-pressures. sample is always valid, and sample_tick marks the
// edges on which it moved to a new phase.
//
// master: keypad/input stage (drives controls, observes outputs).
// slave : wave_osc.
// ---------------------------------------------------------------------------
interface wave_osc_if;
    logic [17:0] divider;
    logic [1:0]  mode;
    logic        strobe;
    logic [7:0]  sample;
    logic        sample_tick;
    logic        active;
    logic [1:0]  dbg_state;

    modport master (
        output divider, mode, strobe,
        input  sample, sample_tick, active, dbg_state
    );

    modport slave (
        input  divider, mode, strobe,
        output sample, sample_tick, active, dbg_state
    );
endinterface

// File: rtl/wave_osc.sv
// ---------------------------------------------------------------------------
// wave_osc -- tone oscillator: phase counter, waveform synthesiser
// (square / saw / triangle / sine) and gate state machine.
//
// Ports:
//   clk   system clock
//   nrst  asynchronous active-low reset
//   osc   wave_osc_if.slave: divider, mode, strobe in;
//         sample, sample_tick, active, dbg_state out
//
// Parameters:
//   PHASE_W  phase accumulator width (>= 8); the waveform is addressed by
//            the top 8 phase bits, one period = 2^PHASE_W steps
//   ENV_DIV  clk cycles per envelope amplitude step (ENVELOPE_EN only)
//
// Optional feature macro: ENVELOPE_EN
//   Undefined: states IDLE/RUN, sample is the raw waveform.
//   Defined:   adds ATTACK/RELEASE states and an 8-bit amplitude that
//              scales the waveform around midscale.
// ---------------------------------------------------------------------------
module wave_osc #(
    parameter int PHASE_W = 8
`ifdef ENVELOPE_EN
    ,
    parameter int ENV_DIV = 1000
`endif
) (
    input  logic      clk,
    input  logic      nrst,
    wave_osc_if.slave osc
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_ATTACK  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // First quadrant of round(127*sin(2*pi*i/256)), i = 0..63.
    localparam logic [6:0] SINE_ROM [64] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
    };

    function automatic logic [7:0] wave_fn(input logic [7:0] ph, input logic [1:0] md);
        logic [5:0] idx;
        logic [7:0] mag;
        // Second and fourth quadrants walk the table backwards.
        idx = ph[6] ? ~ph[5:0] : ph[5:0];
        mag = {1'b0, SINE_ROM[idx]};
        case (md)
            2'd0:    wave_fn = ph[7] ? 8'd255 : 8'd0;
            2'd1:    wave_fn = ph;
            2'd2:    wave_fn = ph[7] ? {~ph[6:0], 1'b0} : {ph[6:0], 1'b0};
            default: wave_fn = ph[7] ? (8'd128 - mag) : (8'd128 + mag);
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [17:0]        count_q, count_d;
    logic [7:0]         sample_q, sample_d;
    logic               tick_q, tick_d;
    logic               active_q;
    logic [7:0]         wave_nxt;
    logic [7:0]         shaped;

`ifdef ENVELOPE_EN
    localparam int ENV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

    logic [7:0]       amp_q, amp_d;
    logic [ENV_W-1:0] env_cnt_q, env_cnt_d;
    logic             env_step;

    assign env_step = (env_cnt_q == ENV_W'(ENV_DIV - 1));
`endif

    // Next-state, phase counter and envelope.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        tick_d  = 1'b0;
`ifdef ENVELOPE_EN
        amp_d     = amp_q;
        env_cnt_d = env_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (osc.strobe) begin
                    state_d   = S_ATTACK;
                    phase_d   = '0;
                    count_d   = '0;
                    env_cnt_d = '0;
                end
            end
            S_ATTACK: begin
                if (!osc.strobe) begin
                    state_d   = S_RELEASE;
                    env_cnt_d = '0;
                end else if (amp_q == 8'd255) begin
                    state_d = S_RUN;
                end else if (env_step) begin
                    env_cnt_d = '0;
                    amp_d     = amp_q + 8'd1;
                    if (amp_q == 8'd254) state_d = S_RUN;
                end else begin
                    env_cnt_d = env_cnt_q + ENV_W'(1);
                end
            end
            S_RUN: begin
                if (!osc.strobe) begin
                    state_d   = S_RELEASE;
                    env_cnt_d = '0;
                end
            end
            default: begin // S_RELEASE
                if (osc.strobe) begin
                    // Re-attack from the current amplitude; phase keeps going.
                    state_d   = S_ATTACK;
                    env_cnt_d = '0;
                end else if (amp_q == 8'd0) begin
                    state_d = S_IDLE;
                end else if (env_step) begin
                    env_cnt_d = '0;
                    amp_d     = amp_q - 8'd1;
                    if (amp_q == 8'd1) state_d = S_IDLE;
                end else begin
                    env_cnt_d = env_cnt_q + ENV_W'(1);
                end
            end
        endcase
`else
        case (state_q)
            S_IDLE: begin
                if (osc.strobe) begin
                    state_d = S_RUN;
                    phase_d = '0;
                    count_d = '0;
                end
            end
            S_RUN: begin
                if (!osc.strobe) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`endif

        // The phase only moves while the note stays sounding across the edge;
        // a note ending on a would-be step edge produces no tick.
        if ((state_q != S_IDLE) && (state_d != S_IDLE) && (osc.divider != 18'd0)) begin
            // >= rather than == so a shrinking divider wraps at once.
            if (count_q >= (osc.divider - 18'd1)) begin
                count_d = '0;
                phase_d = phase_q + PHASE_W'(1);
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + 18'd1;
            end
        end

        if (state_d == S_IDLE) count_d = '0;
    end

    // Waveform of the phase being loaded this edge, so a phase step reaches
    // sample on the same edge.
    assign wave_nxt = wave_fn(phase_d[PHASE_W-1 -: 8], osc.mode);

`ifdef ENVELOPE_EN
    logic signed [8:0]  w_c, a_c;
    logic signed [17:0] prod;
    logic signed [9:0]  scaled;

    always_comb begin
        w_c    = $signed({1'b0, wave_nxt}) - 9'sd128;
        a_c    = $signed({1'b0, amp_d});
        prod   = 18'(w_c) * 18'(a_c);
        scaled = 10'(prod >>> 8) + 10'sd128;
        // Full amplitude is unity gain, so the sustained note hits 0..255.
        if (amp_d == 8'd255)          shaped = wave_nxt;
        else if (scaled < 10'sd0)     shaped = 8'd0;
        else if (scaled > 10'sd255)   shaped = 8'd255;
        else                          shaped = scaled[7:0];
    end
`else
    assign shaped = wave_nxt;
`endif

    assign sample_d = (state_d == S_IDLE) ? 8'd128 : shaped;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            count_q   <= '0;
            sample_q  <= 8'd128;
            tick_q    <= 1'b0;
            active_q  <= 1'b0;
`ifdef ENVELOPE_EN
            amp_q     <= 8'd0;
            env_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            count_q   <= count_d;
            sample_q  <= sample_d;
            tick_q    <= tick_d;
            active_q  <= (state_q != S_IDLE);
`ifdef ENVELOPE_EN
            amp_q     <= amp_d;
            env_cnt_q <= env_cnt_d;
`endif
        end
    end

    assign osc.sample      = sample_q;
    assign osc.sample_tick = tick_q;
    assign osc.active      = active_q;
    assign osc.dbg_state   = state_q;

endmodule

// File: tb/tb_wave_osc.sv
// ---------------------------------------------------------------------------
// tb_wave_osc -- self-checking bench for wave_osc.
// Reference model: note-held flag, integer phase/count and an arithmetic
// waveform function (sine from $sin). Inputs change 1 ns after the rising
// edge; outputs are checked 1 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wave_osc;

    logic clk;
    logic nrst;
    wave_osc_if bus();

`ifdef ENVELOPE_EN
    wave_osc #(.PHASE_W(8), .ENV_DIV(2)) dut (.clk(clk), .nrst(nrst), .osc(bus));
`else
    wave_osc #(.PHASE_W(8)) dut (.clk(clk), .nrst(nrst), .osc(bus));
`endif

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    bit m_run;
    int m_phase;
    int m_cnt;
    bit m_tick_exp;
    bit m_active_exp;
    int m_sample_exp;

    function automatic int wave_ref(input int ph, input int md);
        real pi_v;
        int  idx;
        int  mag;
        pi_v = 3.14159265358979;
        case (md)
            0: return (ph >= 128) ? 255 : 0;
            1: return ph;
            2: return (ph < 128) ? 2 * ph : 2 * (255 - ph);
            default: begin
                idx = ph % 64;
                if (((ph / 64) % 2) == 1) idx = 63 - idx;
                mag = $rtoi(127.0 * $sin(2.0 * pi_v * idx / 256.0) + 0.5);
                return (ph >= 128) ? 128 - mag : 128 + mag;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_run        = 1'b0;
        m_phase      = 0;
        m_cnt        = 0;
        m_tick_exp   = 1'b0;
        m_active_exp = 1'b0;
        m_sample_exp = 128;
    endtask

    // Called right at a rising edge, before any input changes.
    task automatic model_edge();
        bit s;
        int div;
        int md;
        s   = bus.strobe;
        div = int'(bus.divider);
        md  = int'(bus.mode);
        m_active_exp = m_run;
        m_tick_exp   = 1'b0;
        if (!m_run) begin
            if (s) begin
                m_run   = 1'b1;
                m_phase = 0;
                m_cnt   = 0;
            end
        end else if (!s) begin
            m_run = 1'b0;
            m_cnt = 0;
        end else if (div > 0) begin
            if (m_cnt >= div - 1) begin
                m_cnt      = 0;
                m_phase    = (m_phase + 1) % 256;
                m_tick_exp = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        m_sample_exp = m_run ? wave_ref(m_phase, md) : 128;
    endtask

    task automatic go_idle();
        bus.strobe = 1'b0;
        repeat (2) begin
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nrst        = 1'b0;
        bus.strobe  = 1'b1;
        bus.divider = 18'd5;
        bus.mode    = 2'd1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.sample !== 8'd128) begin bad++; $display("FAIL reset_sample got=%0d exp=128", bus.sample); end
        total++; if (bus.sample_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%0b exp=0", bus.sample_tick); end
        total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL reset_active got=%0b exp=0", bus.active); end
        nrst = 1'b1;
        @(posedge clk); model_edge(); #1;
        total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL active_edge0 got=%0b exp=0", bus.active); end
        @(posedge clk); model_edge(); #1;
        total++; if (bus.active !== 1'b1) begin bad++; $display("FAIL active_edge1 got=%0b exp=1", bus.active); end
    endtask

    task automatic test_saw();
        bit wrap_seen;
        int prev;
        go_idle();
        bus.mode    = 2'd1;
        bus.divider = 18'd2;
        bus.strobe  = 1'b1;
        wrap_seen   = 1'b0;
        prev        = -1;
        for (int k = 0; k < 530; k++) begin
            @(posedge clk); model_edge(); #1;
            total++; if (bus.sample !== 8'(m_sample_exp)) begin bad++; $display("FAIL saw_sample k=%0d got=%0d exp=%0d", k, bus.sample, m_sample_exp); end
            total++; if (bus.sample_tick !== m_tick_exp) begin bad++; $display("FAIL saw_tick k=%0d got=%0b exp=%0b", k, bus.sample_tick, m_tick_exp); end
            total++; if (bus.active !== m_active_exp) begin bad++; $display("FAIL saw_active k=%0d got=%0b exp=%0b", k, bus.active, m_active_exp); end
            if (prev == 255 && int'(bus.sample) == 0) wrap_seen = 1'b1;
            prev = int'(bus.sample);
        end
        total++; if (wrap_seen !== 1'b1) begin bad++; $display("FAIL saw_wrap got=%0b exp=1", wrap_seen); end
    endtask

    task automatic test_square_triangle();
        for (int md = 0; md <= 2; md += 2) begin
            go_idle();
            bus.mode    = 2'(md);
            bus.divider = 18'd1;
            bus.strobe  = 1'b1;
            for (int k = 0; k < 260; k++) begin
                @(posedge clk); model_edge(); #1;
                total++; if (bus.sample !== 8'(m_sample_exp)) begin bad++; $display("FAIL sqtri_sample mode=%0d k=%0d got=%0d exp=%0d", md, k, bus.sample, m_sample_exp); end
                total++; if (bus.sample_tick !== m_tick_exp) begin bad++; $display("FAIL sqtri_tick mode=%0d k=%0d got=%0b exp=%0b", md, k, bus.sample_tick, m_tick_exp); end
            end
        end
    endtask

    task automatic test_sine();
        int spot;
        go_idle();
        bus.mode    = 2'd3;
        bus.divider = 18'd1;
        bus.strobe  = 1'b1;
        for (int k = 0; k < 260; k++) begin
            @(posedge clk); model_edge(); #1;
            total++; if (bus.sample !== 8'(m_sample_exp)) begin bad++; $display("FAIL sine_sample k=%0d got=%0d exp=%0d", k, bus.sample, m_sample_exp); end
            case (m_phase)
                0:       spot = 128;
                64:      spot = 255;
                128:     spot = 128;
                192:     spot = 1;
                default: spot = -1;
            endcase
            if (spot >= 0) begin
                total++; if (bus.sample !== 8'(spot)) begin bad++; $display("FAIL sine_spot phase=%0d got=%0d exp=%0d", m_phase, bus.sample, spot); end
            end
        end
    endtask

    task automatic test_midnote();
        int hold;
        go_idle();
        bus.mode    = 2'd1;
        bus.divider = 18'd100;
        bus.strobe  = 1'b1;
        for (int k = 0; k <= 50; k++) begin
            @(posedge clk); model_edge(); #1;
            total++; if (bus.sample_tick !== m_tick_exp) begin bad++; $display("FAIL mid_tick100 k=%0d got=%0b exp=%0b", k, bus.sample_tick, m_tick_exp); end
        end
        bus.divider = 18'd3;
        @(posedge clk); model_edge(); #1;
        total++; if (bus.sample_tick !== 1'b1) begin bad++; $display("FAIL mid_shrink_tick got=%0b exp=1", bus.sample_tick); end
        total++; if (bus.sample !== 8'd1) begin bad++; $display("FAIL mid_shrink_sample got=%0d exp=1", bus.sample); end
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); model_edge(); #1;
            total++; if (bus.sample_tick !== m_tick_exp) begin bad++; $display("FAIL mid_tick3 k=%0d got=%0b exp=%0b", k, bus.sample_tick, m_tick_exp); end
            total++; if (bus.sample !== 8'(m_sample_exp)) begin bad++; $display("FAIL mid_sample3 k=%0d got=%0d exp=%0d", k, bus.sample, m_sample_exp); end
        end
        bus.divider = 18'd0;
        hold = m_sample_exp;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); model_edge(); #1;
            total++; if (bus.sample !== 8'(hold)) begin bad++; $display("FAIL mid_frozen k=%0d got=%0d exp=%0d", k, bus.sample, hold); end
            total++; if (bus.sample_tick !== 1'b0) begin bad++; $display("FAIL mid_frozen_tick k=%0d got=%0b exp=0", k, bus.sample_tick); end
        end
        bus.strobe = 1'b0;
        @(posedge clk); model_edge(); #1;
        total++; if (bus.sample !== 8'd128) begin bad++; $display("FAIL mid_release got=%0d exp=128", bus.sample); end
    endtask

    task automatic test_random();
        go_idle();
        bus.strobe  = 1'b1;
        bus.divider = 18'd1;
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); model_edge(); #1;
            total++; if (bus.sample !== 8'(m_sample_exp)) begin bad++; $display("FAIL rnd_sample k=%0d got=%0d exp=%0d", k, bus.sample, m_sample_exp); end
            total++; if (bus.sample_tick !== m_tick_exp) begin bad++; $display("FAIL rnd_tick k=%0d got=%0b exp=%0b", k, bus.sample_tick, m_tick_exp); end
            total++; if (bus.active !== m_active_exp) begin bad++; $display("FAIL rnd_active k=%0d got=%0b exp=%0b", k, bus.active, m_active_exp); end
            if ($urandom_range(0, 19) == 0) bus.strobe = ~bus.strobe;
            if ($urandom_range(0, 29) == 0) bus.divider = 18'($urandom_range(0, 5));
            if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic test_async_reset();
        go_idle();
        bus.mode    = 2'd1;
        bus.divider = 18'd1;
        bus.strobe  = 1'b1;
        repeat (20) begin
            @(posedge clk); model_edge(); #1;
        end
        #2 nrst = 1'b0;
        model_reset();
        #1;
        total++; if (bus.sample !== 8'd128) begin bad++; $display("FAIL arst_sample got=%0d exp=128", bus.sample); end
        total++; if (bus.active !== 1'b0) begin bad++; $display("FAIL arst_active got=%0b exp=0", bus.active); end
        total++; if (bus.sample_tick !== 1'b0) begin bad++; $display("FAIL arst_tick got=%0b exp=0", bus.sample_tick); end
        @(posedge clk); #1;
        nrst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); model_edge(); #1;
            total++; if (bus.sample !== 8'(m_sample_exp)) begin bad++; $display("FAIL arst_resume k=%0d got=%0d exp=%0d", k, bus.sample, m_sample_exp); end
            total++; if (bus.active !== m_active_exp) begin bad++; $display("FAIL arst_resume_active k=%0d got=%0b exp=%0b", k, bus.active, m_active_exp); end
        end
    endtask

`ifdef ENVELOPE_EN
    // Square wave scaled by amp; amp 255 passes the waveform through.
    function automatic int env_ref(input int ph, input int amp);
        int w;
        w = (ph >= 128) ? 255 : 0;
        if (amp >= 255) return w;
        return 128 + (((w - 128) * amp) >>> 8);
    endfunction

    task automatic test_envelope();
        int n;
        int amp;
        int e;
        int a_top;
        bus.strobe = 1'b0;
        nrst = 1'b0;
        #3 nrst = 1'b1;
        bus.mode    = 2'd0;
        bus.divider = 18'd1;
        bus.strobe  = 1'b1;
        n = 0;
        for (int k = 0; k < 520; k++) begin
            @(posedge clk); #1;
            amp = (k / 2 > 255) ? 255 : k / 2;
            e = env_ref(n % 256, amp);
            n++;
            total++; if (bus.sample !== 8'(e)) begin bad++; $display("FAIL env_attack k=%0d got=%0d exp=%0d", k, bus.sample, e); end
            total++; if (bus.active !== (k >= 1)) begin bad++; $display("FAIL env_attack_active k=%0d got=%0b", k, bus.active); end
            if (k == 510) begin
                total++; if (bus.sample !== 8'd255) begin bad++; $display("FAIL env_peak got=%0d exp=255", bus.sample); end
            end
        end
        bus.strobe = 1'b0;
        for (int r = 0; r <= 310; r++) begin
            @(posedge clk); #1;
            amp = 255 - r / 2;
            e = env_ref(n % 256, amp);
            n++;
            total++; if (bus.sample !== 8'(e)) begin bad++; $display("FAIL env_release r=%0d got=%0d exp=%0d", r, bus.sample, e); end
        end
        bus.strobe = 1'b1;
        for (int a = 0; a < 20; a++) begin
            @(posedge clk); #1;
            amp = 100 + a / 2;
            e = env_ref(n % 256, amp);
            n++;
            total++; if (bus.sample !== 8'(e)) begin bad++; $display("FAIL env_reattack a=%0d got=%0d exp=%0d", a, bus.sample, e); end
        end
        bus.strobe = 1'b0;
        a_top = 109;
        for (int r = 0; r <= 2 * a_top + 1; r++) begin
            @(posedge clk); #1;
            amp = a_top - r / 2;
            if (amp < 0) amp = 0;
            e = (amp == 0) ? 128 : env_ref(n % 256, amp);
            n++;
            total++; if (bus.sample !== 8'(e)) begin bad++; $display("FAIL env_fade r=%0d got=%0d exp=%0d", r, bus.sample, e); end
            total++; if (bus.active !== (r <= 2 * a_top)) begin bad++; $display("FAIL env_fade_active r=%0d got=%0b", r, bus.active); end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
`ifdef ENVELOPE_EN
        test_envelope();
`else
        test_saw();
        test_square_triangle();
        test_sine();
        test_midnote();
        test_random();
        test_async_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_osc.md
Name: wave_osc

Overview:
- Tone oscillator directly downstream of the keypad/input stage.
- Consumes the note divider, the waveform mode and the key-held strobe, and produces an 8-bit unsigned audio sample stream.
- The sample is centred at 128 and feeds the PWM/DAC output stage.
- Contains a phase counter, a waveform synthesiser (square/saw/triangle/sine) and a gate state machine.

Parameters:
- PHASE_W, 8, phase accumulator width; one waveform period = 2^PHASE_W steps.
- ENV_DIV, 1000, clk cycles per envelope amplitude step (only used with ENVELOPE_EN).

Ports:
- clk  input  1  system clock.
- nrst  input  1  asynchronous active-low reset.
- divider  input  18  clk cycles per phase step; 0 = oscillator halted.
- mode  input  2  waveform select: 0 square, 1 sawtooth, 2 triangle, 3 sine.
- strobe  input  1  level; high while a note key is held.
- sample  output  8  registered unsigned audio sample, midscale 128.
- sample_tick  output  1  one-cycle pulse each phase advance.
- active  output  1  high while the FSM is not IDLE.

Behaviour:
- Reset (nrst low, async): state IDLE, phase=0, count=0, sample=128, sample_tick=0, active=0.
- FSM states: IDLE and RUN; ATTACK and RELEASE are added under ENVELOPE_EN (see below).
- IDLE -> RUN when strobe is sampled high. On that edge: phase=0, count=0.
- RUN -> IDLE when strobe is sampled low. On that edge: phase held, count=0.
- Phase counter (RUN only):
  - Each edge: if divider==0, count and phase hold.
  - Else if count >= divider-1: count=0, phase=phase+1 (mod 256, wraps 255->0), sample_tick=1 on that same edge.
  - Else: count=count+1, sample_tick=0.
  - The >= compare makes a divider decrease mid-note wrap on the next edge, with no long stall.
- Waveform w(phase, mode), combinational:
  - square: phase[7] ? 255 : 0.
  - saw: phase.
  - triangle: phase[7] ? {~phase[6:0],1'b0} : {phase[6:0],1'b0} (range 0..254).
  - sine: 128 + round(127*sin(2*pi*phase/256)), from a 64-entry quarter-wave ROM. Index is phase[5:0], mirrored when phase[6]=1; sign from phase[7].
- Sample register, each edge:
  - sample = 128 when the next state is IDLE;
  - otherwise sample = w(next phase, current mode).
  - Latency: phase change to sample is 0 extra cycles (same edge); mode change appears on the next edge.
- active = registered (state != IDLE).
- Simultaneous events:
  - strobe falls on the same edge as a phase step: IDLE wins, sample=128, sample_tick=0.
  - divider changes while the note is held: no phase reset.
- Async reset mid-note: all outputs return to reset values immediately.

Optional Feature:
- Macro ENVELOPE_EN.
- Defined:
  - Adds ATTACK and RELEASE states and an 8-bit amp register, reset value 0.
  - Transitions:
    - IDLE -> ATTACK on strobe (phase=0).
    - ATTACK: amp+1 every ENV_DIV clks, saturates at 255 -> RUN.
    - RUN -> RELEASE on strobe low.
    - RELEASE: amp-1 every ENV_DIV clks; at amp==0 -> IDLE.
    - strobe high during RELEASE -> ATTACK from the current amp; phase continues.
  - The phase counter runs in ATTACK, RUN and RELEASE.
  - sample = 128 + ((w-128)*amp)>>>8, signed arithmetic on 9-bit x 9-bit, result clamped to 0..255.
- Undefined: amp is implicitly 255 and sample = w exactly; no ATTACK/RELEASE states; ENV_DIV unused.

Test Plan:
- Reset: hold nrst=0 with strobe=1 and divider=5 -> sample=128, sample_tick=0, active=0. Release nrst -> active=1 one edge after strobe is sampled.
- Saw, divider=2: strobe high -> sample sequence 0,0,1,1,2,... A sample_tick every 2nd clk. After 512 clks, phase wraps 255->0 and sample 255 is followed by 0.
- Square and triangle, divider=1: phase steps every clk. Square gives 0 x128 then 255 x128. Triangle peaks at 254 at phase 127, then gives 254 at phase 128 and 0 at phase 255.
- Sine, divider=1: phase 0 -> 128, 64 -> 255, 128 -> 128, 192 -> 1.
- Mid-note changes: divider 100 -> 3 while count=50 -> phase steps on the next edge, then every 3 clks. divider=0 -> phase frozen, sample constant. strobe low -> sample=128 on the next edge.
- With ENVELOPE_EN, ENV_DIV=2, square: amp ramps 0->255 over 510 clks and peak sample reaches 255. Release to amp 100, then strobe high -> ATTACK resumes from 100. active drops only when amp reaches 0.
